// File: rtl/mem_write_monitor.sv
`timescale 1ns/1ps
// mem_write_monitor
// Watches the mips store bus and keeps every store in a first-word-fall-through
// FIFO. A valid/ready port drains the FIFO to a checker or log sink. Once
// exmemory raises kraj, capture stops. The unit raises done after the last
// queued store has been handed off.
module mem_write_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [WIDTH-1:0]         adr,
  input  logic [WIDTH-1:0]         writedata,
  input  logic                     kraj,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_adr,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] adrMem  [DEPTH];
  logic [WIDTH-1:0] dataMem [DEPTH];

  logic isEmpty;
  logic isFull;
  logic pushReq;
  logic pushEn;
  logic popEn;

  // Handshake decode: a pop is allowed when data is present. A push is
  // accepted when there is room, or when a pop in the same cycle frees the
  // head slot.
  always_comb begin
    isEmpty = (count_q == '0);
    isFull  = (count_q == CW'(DEPTH));
    pushReq = memwrite && (state_q == RUN);
    popEn   = out_ready && !isEmpty;
    pushEn  = pushReq && (!isFull || popEn);
  end

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pushReq && isFull && !popEn) begin
      overflow_d = 1'b1;
    end
  end

  // Program-phase FSM. The design moves to DONE only when the occupancy after
  // this edge is zero, so done can never rise while entries remain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (kraj) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    done_d = (state_d == DONE);
  end

  // Control state registers. These clear asynchronously, which discards all
  // queued entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Storage array. Its contents need no reset because the zero count hides them.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      adrMem[wrPtr_q]  <= adr;
      dataMem[wrPtr_q] <= writedata;
    end
  end

  // Output view of the head entry. It is forced to zero while the FIFO is empty.
  always_comb begin
    out_valid = !isEmpty;
    out_adr   = isEmpty ? '0 : adrMem[rdPtr_q];
    out_data  = isEmpty ? '0 : dataMem[rdPtr_q];
    count     = count_q;
    overflow  = overflow_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_mem_write_monitor.sv
`timescale 1ns/1ps
// tb_mem_write_monitor
// Directed scenarios plus randomized traffic. The outputs are compared on
// every negedge against a queue-based model of the store log.
module tb_mem_write_monitor;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             memwrite = 1'b0;
  logic [WIDTH-1:0] adr = '0;
  logic [WIDTH-1:0] writedata = '0;
  logic             kraj = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_adr;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             done;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  mem_write_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .kraj(kraj), .out_ready(out_ready),
    .out_valid(out_valid), .out_adr(out_adr), .out_data(out_data),
    .count(count), .overflow(overflow), .done(done)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Reference model. The store log is a queue. The model also tracks whether
  // the program has ended and whether the log has been drained since then.
  logic [2*WIDTH-1:0] mq[$];
  bit mOverflow, mEnded, mDone;
  bit mPop, mWantPush, mWasEnded;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mOverflow = 1'b0;
      mEnded    = 1'b0;
      mDone     = 1'b0;
    end else begin
      mWasEnded = mEnded;
      mPop      = (mq.size() > 0) && out_ready;
      mWantPush = memwrite && !mEnded;
      if (mPop) void'(mq.pop_front());
      if (mWantPush) begin
        if (mq.size() < DEPTH) mq.push_back({adr, writedata});
        else mOverflow = 1'b1;
      end
      if (kraj) mEnded = 1'b1;
      if (mWasEnded && mq.size() == 0) mDone = 1'b1;
    end
  end

  // Single comparison point that counts checks and failures.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("cyc valid", 32'(out_valid), 32'(mq.size() != 0));
      checkOutput("cyc count", 32'(count), 32'(mq.size()));
      checkOutput("cyc adr", 32'(out_adr), (mq.size() != 0) ? 32'(mq[0][2*WIDTH-1:WIDTH]) : 32'd0);
      checkOutput("cyc data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0][WIDTH-1:0]) : 32'd0);
      checkOutput("cyc overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("cyc done", 32'(done), 32'(mDone));
    end
  end

  // Drive one cycle of inputs at a negedge and return at the following negedge.
  task automatic applyStimulus(input logic mw, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] d, input logic k, input logic rdy);
    memwrite  = mw;
    adr       = a;
    writedata = d;
    kraj      = k;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic doReset();
    memwrite = 1'b0; kraj = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Guard against a hung run.
  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    printSummary();
    $finish;
  end

  initial begin
    logic             mw, k, rdy;
    logic [WIDTH-1:0] a, d;
    int               rdyPct;

    // Test 1: reset state, then an idle period.
    @(negedge clk);
    checkOutput("t1 reset valid", 32'(out_valid), 32'd0);
    checkOutput("t1 reset count", 32'(count), 32'd0);
    checkOutput("t1 reset adr", 32'(out_adr), 32'd0);
    reset = 1'b0;
    checkEn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      checkOutput("t1 idle valid", 32'(out_valid), 32'd0);
      checkOutput("t1 idle count", 32'(count), 32'd0);
      checkOutput("t1 idle done", 32'(done), 32'd0);
      checkOutput("t1 idle overflow", 32'(overflow), 32'd0);
    end

    // Test 2: two stores are held, then drained in order.
    applyStimulus(1'b1, 8'h10, 8'h07, 1'b0, 1'b0);
    checkOutput("t2 latency count", 32'(count), 32'd1);
    applyStimulus(1'b1, 8'h4C, 8'h07, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t2 count", 32'(count), 32'd2);
    checkOutput("t2 model size", 32'(mq.size()), 32'd2);
    checkOutput("t2 head adr", 32'(out_adr), 32'h10);
    checkOutput("t2 head data", 32'(out_data), 32'h07);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t2 pop1 count", 32'(count), 32'd1);
    checkOutput("t2 pop1 adr", 32'(out_adr), 32'h4C);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t2 pop2 count", 32'(count), 32'd0);
    checkOutput("t2 empty adr", 32'(out_adr), 32'd0);

    // Test 3: overfill by one store, then drain exactly the first eight.
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t3 count", 32'(count), 32'd8);
    checkOutput("t3 overflow", 32'(overflow), 32'd1);
    checkOutput("t3 model overflow", 32'(mOverflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("t3 head adr", 32'(out_adr), 32'(i));
      checkOutput("t3 head data", 32'(out_data), 32'(8'h80 + i));
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("t3 drained count", 32'(count), 32'd0);
    checkOutput("t3 overflow sticky", 32'(overflow), 32'd1);

    // Test 4: push and pop together while the FIFO is full.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h20 + i), 8'(8'hA0 + i), 1'b0, 1'b0);
    checkOutput("t4 full count", 32'(count), 32'd8);
    applyStimulus(1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
    checkOutput("t4 count held", 32'(count), 32'd8);
    checkOutput("t4 no overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      checkOutput("t4 head adr", 32'(out_adr), 32'(8'h20 + i));
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("t4 last adr", 32'(out_adr), 32'h55);
    checkOutput("t4 last data", 32'(out_data), 32'h66);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t4 empty", 32'(count), 32'd0);

    // Test 5: kraj arrives together with a store; done follows the last pop.
    doReset();
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(i), 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
    checkOutput("t5 count after kraj", 32'(count), 32'd4);
    checkOutput("t5 model size", 32'(mq.size()), 32'd4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0);
    checkOutput("t5 stores ignored", 32'(count), 32'd4);
    checkOutput("t5 done low", 32'(done), 32'd0);
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b1);
      checkOutput("t5 pop count", 32'(count), 32'(4 - p));
      checkOutput("t5 pop done", 32'(done), 32'(p == 4));
    end
    applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b0);
    checkOutput("t5 done held", 32'(done), 32'd1);
    checkOutput("t5 done empty", 32'(count), 32'd0);

    // Test 6: reset asserted between edges clears everything at once.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("t6 count before", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6 async count", 32'(count), 32'd0);
    checkOutput("t6 async valid", 32'(out_valid), 32'd0);
    checkOutput("t6 async done", 32'(done), 32'd0);
    checkOutput("t6 async adr", 32'(out_adr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h77, 8'h88, 1'b0, 1'b0);
    checkOutput("t6 resume count", 32'(count), 32'd1);
    checkOutput("t6 resume adr", 32'(out_adr), 32'h77);
    checkOutput("t6 resume data", 32'(out_data), 32'h88);

    // Randomized traffic. Each round uses a different sink readiness so that
    // both the empty and the overflow regions get exercised.
    for (int r = 0; r < 6; r++) begin
      doReset();
      rdyPct = r * 20;
      for (int c = 0; c < 500; c++) begin
        mw  = 1'($urandom_range(0, 99) < 60);
        rdy = 1'($urandom_range(0, 99) < rdyPct);
        k   = 1'($urandom_range(0, 199) == 0);
        a   = 8'($urandom);
        d   = 8'($urandom);
        applyStimulus(mw, a, d, k, rdy);
      end
    end

    checkEn = 1'b0;
    printSummary();
    $finish;
  end

endmodule
